// File: rtl/hlsm_drv_pkg.sv
// hlsm_drv_pkg: shared widths, defaults, FSM encoding and operand-job record for hlsm_driver.
package hlsm_drv_pkg;
   localparam int DATA_W         = 32;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_WAIT_LIMIT = 32;
   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_HOLD} state_t;
   typedef struct packed {
      logic signed [DATA_W-1:0] a;
      logic signed [DATA_W-1:0] b;
      logic signed [DATA_W-1:0] c;
      logic signed [DATA_W-1:0] one;
   } op_t;
endpackage

// File: rtl/hlsm_op_fifo.sv
// hlsm_op_fifo: synchronous FIFO of operand jobs with occupancy count; push when full / pop when empty are ignored.
module hlsm_op_fifo
   import hlsm_drv_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     push_i,
   input  op_t                      din_i,
   input  logic                     pop_i,
   output op_t                      dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   op_t            mem_q [DEPTH];
   logic [AW-1:0]  wr_q, rd_q;
   logic [CW-1:0]  cnt_q;
   logic           push_ok, pop_ok;
   assign push_ok = push_i && cnt_q != CW'(DEPTH);
   assign pop_ok  = pop_i && cnt_q != '0;
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   always_ff @(posedge Clk) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(push_ok);
         rd_q  <= rd_q + AW'(pop_ok);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/hlsm_driver.sv
// hlsm_driver: queues operand jobs and runs them one at a time through a downstream HLSM,
// holding each result for a consumer and flagging jobs whose Done never arrives.
module hlsm_driver
   import hlsm_drv_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int WAIT_LIMIT = DEF_WAIT_LIMIT
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_a,
   input  logic signed [DATA_W-1:0]  in_b,
   input  logic signed [DATA_W-1:0]  in_c,
   input  logic signed [DATA_W-1:0]  in_one,
   output logic signed [DATA_W-1:0]  hl_a,
   output logic signed [DATA_W-1:0]  hl_b,
   output logic signed [DATA_W-1:0]  hl_c,
   output logic signed [DATA_W-1:0]  hl_one,
   output logic                      hl_start,
   input  logic                      hl_done,
   input  logic signed [DATA_W-1:0]  hl_x,
   input  logic signed [DATA_W-1:0]  hl_z,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  out_x,
   output logic signed [DATA_W-1:0]  out_z,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      err
);
   localparam int CNTW = $clog2(DEPTH) + 1;
   localparam int WCW  = $clog2(WAIT_LIMIT + 1);
   state_t                    state_q;
   op_t                       op_q, head, push_op;
   logic [WCW-1:0]            wcnt_q;
   logic                      done_q, start_q, valid_q, err_q;
   logic                      push, pop, done_ev;
   logic signed [DATA_W-1:0]  x_q, z_q;
   assign in_ready  = fifo_count < CNTW'(DEPTH);
   assign push      = in_valid && in_ready;
   assign pop       = state_q == ST_IDLE && fifo_count != '0;
   // Only a rising Done counts, so a level left high by the previous job is ignored.
   assign done_ev   = hl_done && !done_q;
   assign push_op   = '{a: in_a, b: in_b, c: in_c, one: in_one};
   assign hl_a      = op_q.a;
   assign hl_b      = op_q.b;
   assign hl_c      = op_q.c;
   assign hl_one    = op_q.one;
   assign hl_start  = start_q;
   assign out_valid = valid_q;
   assign out_x     = x_q;
   assign out_z     = z_q;
   assign err       = err_q;
   hlsm_op_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clk     (Clk),
      .Rst     (Rst),
      .push_i  (push),
      .din_i   (push_op),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (fifo_count)
   );
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         wcnt_q  <= '0;
         done_q  <= 1'b0;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         x_q     <= '0;
         z_q     <= '0;
      end else begin
         done_q  <= hl_done;
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (pop) begin
               op_q    <= head;
               start_q <= 1'b1;
               state_q <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
               wcnt_q  <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: if (done_ev) begin
               x_q     <= hl_x;
               z_q     <= hl_z;
               valid_q <= 1'b1;
               state_q <= ST_HOLD;
            end else if (wcnt_q == WCW'(WAIT_LIMIT - 1)) begin
               err_q   <= 1'b1;
               state_q <= ST_IDLE;
            end else begin
               wcnt_q  <= wcnt_q + 1'b1;
            end
            ST_HOLD: if (out_ready) begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hlsm_driver.sv
// tb_hlsm_driver: randomized and directed stimulus against a job-level reference model with a
// queue scoreboard; a behavioural HLSM stub computes x = a+b-c, z = c-one after a fixed latency.
module tb_hlsm_driver;
   import hlsm_drv_pkg::*;
   localparam int DEPTH = 4;
   localparam int WL    = 32;
   localparam int LAT   = 11;
   localparam int M_NORMAL = 0, M_STALE = 1, M_HANG = 2;
   logic Clk = 1'b0, Rst = 1'b1;
   logic in_valid = 1'b0, in_ready, hl_start, hl_done, out_valid, out_ready = 1'b1, err;
   logic signed [31:0] in_a = 0, in_b = 0, in_c = 0, in_one = 0;
   logic signed [31:0] hl_a, hl_b, hl_c, hl_one, hl_x, hl_z, out_x, out_z;
   logic [$clog2(DEPTH):0] fifo_count;
   int mode = M_NORMAL;
   int cyc = 0;
   int n_cmp = 0, n_bad = 0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;
   hlsm_driver #(.DEPTH(DEPTH), .WAIT_LIMIT(WL)) dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_one(in_one),
      .hl_a(hl_a), .hl_b(hl_b), .hl_c(hl_c), .hl_one(hl_one),
      .hl_start(hl_start), .hl_done(hl_done), .hl_x(hl_x), .hl_z(hl_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_z(out_z),
      .fifo_count(fifo_count), .err(err)
   );
   // HLSM stub: normal clears Done at start, stale keeps the old Done high then drops and re-raises it,
   // hang never raises Done. Results read as noise until Done rises.
   int s_cnt;
   logic signed [31:0] s_x, s_z;
   always @(posedge Clk) begin
      if (Rst) begin
         s_cnt <= 0; hl_done <= 1'b0; hl_x <= 0; hl_z <= 0;
      end else if (hl_start) begin
         s_cnt <= (mode == M_HANG) ? 0 : 1;
         s_x <= hl_a + hl_b - hl_c;
         s_z <= hl_c - hl_one;
         hl_x <= $urandom; hl_z <= $urandom;
         if (mode != M_STALE) hl_done <= 1'b0;
      end else if (s_cnt != 0) begin
         if (mode == M_STALE && s_cnt == 4) hl_done <= 1'b0;
         if (s_cnt == LAT) begin
            hl_done <= 1'b1; hl_x <= s_x; hl_z <= s_z; s_cnt <= 0;
         end else s_cnt <= s_cnt + 1;
      end
   end
   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask
   task automatic fail(input string nm);
      n_cmp++; n_bad++;
      $display("FAIL %s: got event, expected none", nm);
   endtask
   // Reference model: jobs in push order, expected results, occupancy and timeout deadlines.
   logic [127:0] launch_q[$];
   logic [63:0]  result_q[$];
   logic [127:0] cur;
   logic [63:0]  exp_r, hold_v;
   int count_m = 0, dl = -1, exp_vcyc = 0;
   bit busy_m = 0, held = 0, err_m = 0, acc_pending = 0, rst_chk = 0;
   always @(negedge Clk) begin
      if (Rst) begin
         launch_q.delete(); result_q.delete();
         count_m = 0; dl = -1; busy_m = 0; held = 0; err_m = 0; acc_pending = 0; rst_chk = 1;
      end else begin
         if (rst_chk) begin
            chk("reset_count", 128'(fifo_count), 0);
            chk("reset_ready", 128'(in_ready), 1);
            chk("reset_flags", {hl_start, out_valid, err}, 0);
            chk("reset_regs", {hl_a, hl_b, hl_c, hl_one}, 0);
            chk("reset_out", {out_x, out_z}, 0);
            rst_chk = 0;
         end
         count_m = count_m + int'(acc_pending) - int'(hl_start);
         if (hl_start) begin
            if (launch_q.size() == 0) fail("spurious_launch");
            else begin
               cur = launch_q.pop_front();
               chk("launch_ops", {hl_a, hl_b, hl_c, hl_one}, cur);
               busy_m = 1;
               exp_vcyc = cyc + LAT + 2;
               dl = (mode == M_HANG) ? cyc + 1 + WL : -1;
            end
         end else if (busy_m) chk("ops_stable", {hl_a, hl_b, hl_c, hl_one}, cur);
         if (cyc == dl) begin
            err_m = 1; busy_m = 0; dl = -1;
         end
         chk("fifo_count", 128'(fifo_count), 128'(count_m));
         chk("in_ready", 128'(in_ready), 128'(count_m < DEPTH));
         chk("err", 128'(err), 128'(err_m));
         if (out_valid) begin
            chk("hold_no_start", 128'(hl_start), 0);
            if (!held) begin
               if (result_q.size() == 0) fail("unexpected_out");
               else begin
                  exp_r = result_q.pop_front();
                  chk("result", {out_x, out_z}, exp_r);
                  chk("result_cycle", 128'(cyc), 128'(exp_vcyc));
               end
               held = 1; busy_m = 0; hold_v = {out_x, out_z};
            end else chk("hold_stable", {out_x, out_z}, hold_v);
            if (out_ready) held = 0;
         end
         acc_pending = in_valid && count_m < DEPTH;
         if (acc_pending) begin
            launch_q.push_back({in_a, in_b, in_c, in_one});
            if (mode != M_HANG) result_q.push_back({in_a + in_b - in_c, in_c - in_one});
         end
      end
   end
   task automatic drive(input logic v, input logic r);
      @(posedge Clk); #1;
      in_valid = v; out_ready = r;
      in_a = $urandom; in_b = $urandom; in_c = $urandom; in_one = $urandom;
   endtask
   task automatic drain();
      int b = 0;
      drive(1'b0, 1'b1);
      while ((launch_q.size() != 0 || result_q.size() != 0 || busy_m || held || count_m != 0 || out_valid) && b < 2000) begin
         @(posedge Clk); b++;
      end
      if (b >= 2000) fail("drain_timeout");
      repeat (2) @(posedge Clk);
   endtask
   task automatic do_reset();
      @(posedge Clk); #1; in_valid = 1'b0; Rst = 1'b1;
      @(posedge Clk); #1; Rst = 1'b0;
   endtask
   initial begin
      int n, b;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      // Known job: 5,3,2,1 -> 6,1 with out_valid 14 edges after the push edge.
      @(posedge Clk); #1;
      in_valid = 1'b1; in_a = 5; in_b = 3; in_c = 2; in_one = 1; out_ready = 1'b1;
      n = cyc + 1;
      @(posedge Clk); #1 in_valid = 1'b0;
      b = 0;
      while (!out_valid && b < 40) begin
         @(negedge Clk); b++;
      end
      chk("known_latency", 128'(cyc - n), 14);
      chk("known_result", {out_x, out_z}, {32'sd6, 32'sd1});
      drain();
      // Back-to-back burst overfills the FIFO; refused jobs are dropped.
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1);
      drain();
      // Consumer stalls during HOLD while new jobs keep arriving.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      b = 0;
      while (!out_valid && b < 60) begin
         @(posedge Clk); b++;
      end
      for (int i = 0; i < 10; i++) drive(i < 3, 1'b0);
      drain();
      for (int i = 0; i < 400; i++) drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      drain();
      // Done already high at launch from the previous job.
      mode = M_STALE;
      drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      drain();
      mode = M_HANG;
      drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      drain();
      mode = M_NORMAL;
      drive(1'b1, 1'b1);
      drain();
      // Reset while the first of three jobs is in WAIT.
      drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
      do_reset();
      drive(1'b1, 1'b1);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
